// File: rtl/config_loader_pkg.sv
// Purpose: shared constants, types and helpers for the configuration chain loader.
//   - Wishbone register offsets (relative to the block base address)
//   - CTRL and STATUS bit positions
//   - Load FSM state encoding
//   - CRC-16-CCITT constants and a single-bit update step
package config_loader_pkg;

  // Register offsets within the 256-byte window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_COLSEL = 8'h04;
  localparam logic [7:0] OFF_LEN    = 8'h08;
  localparam logic [7:0] OFF_DATA   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_CRC    = 8'h14;

  // CTRL bits
  localparam int unsigned CTRL_CEN   = 0;
  localparam int unsigned CTRL_START = 1;

  // STATUS bits
  localparam int unsigned STS_BUSY    = 0;
  localparam int unsigned STS_OVF     = 1;
  localparam int unsigned STS_UNF     = 2;
  localparam int unsigned STS_DONE    = 3;
  localparam int unsigned STS_CNT_LSB = 8;
  localparam int unsigned STS_CNT_W   = 4;

  // CRC-16-CCITT
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_SET   = 2'd3
  } load_state_e;

  // One MSB-first CRC step for a single serial bit
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return fb ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/config_word_fifo.sv
// Purpose: synchronous word FIFO with show-ahead read data and push/pop in the
//   same cycle; a push while full succeeds when a pop happens in that cycle.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_push, i_wdata    write request and word
//   i_pop              read request (ignored when empty)
//   o_rdata_c          head word (combinational)
//   o_full_c, o_empty_c occupancy flags (combinational from the count)
//   o_count            number of stored words
module config_word_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned W     = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata_c,
  output logic          o_full_c,
  output logic          o_empty_c,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // A pop frees the slot a full-FIFO push needs in the same cycle
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  // Pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage (contents are don't-care until written)
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/config_chain_loader.sv
// Purpose: Wishbone-slave bitstream loader. Firmware pushes 32-bit words into a
//   FIFO; on START the words are shifted LSB-first into the masked column chains
//   for LEN bits, followed by a single set pulse. Also owns the fabric cen.
// Optional build macro: CONFIG_CRC_EN adds a CRC-16-CCITT over every shifted bit,
//   readable at offset 0x14 (reads 0 when the macro is undefined).
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (registered single-cycle ack)
//   cen                         fabric configuration enable (CTRL bit0)
//   cfg_data_out/shift_out/set_out  per-column chain data, shift and set strobes
//   busy                        load in progress
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_1000,
  parameter int unsigned NCOL       = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_data_i,
  input  logic [31:0]     wbs_addr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_data_o,
  output logic            cen,
  output logic [NCOL-1:0] cfg_data_out,
  output logic [NCOL-1:0] cfg_shift_out,
  output logic [NCOL-1:0] cfg_set_out,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Bus and register state
  logic             r_ack;
  logic [31:0]      r_rdata;
  logic             r_cen;
  logic [NCOL-1:0]  r_colsel;
  logic [LEN_W-1:0] r_len;
  logic             r_ovf;
  logic             r_unf;
  logic             r_done;

  // Load engine state
  load_state_e      r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [31:0]      r_sr;
  logic [4:0]       r_bitcnt;
  logic [NCOL-1:0]  r_mask;
  logic             r_busy;
  logic [NCOL-1:0]  r_cfg_data;
  logic [NCOL-1:0]  r_cfg_shift;
  logic [NCOL-1:0]  r_cfg_set;
`ifdef CONFIG_CRC_EN
  logic [15:0]      r_crc;
`endif

  logic             w_sel;
  logic             w_wr;
  logic             w_rd;
  logic [7:0]       w_off;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_fifo_rdata;
  logic             w_start;
  logic             w_sts_clr;
  logic [31:0]      w_rdata;

  // Decode: the ack cycle itself never re-selects, guaranteeing a gap after each ack
  assign w_sel     = wbs_stb_i && wbs_cyc_i && (wbs_addr_i[31:8] == BASE_ADDR[31:8]) && !r_ack;
  assign w_wr      = w_sel && wbs_we_i;
  assign w_rd      = w_sel && !wbs_we_i;
  assign w_off     = wbs_addr_i[7:0];
  assign w_push    = w_wr && (w_off == OFF_DATA) && (wbs_sel_i == 4'hF);
  assign w_start   = w_wr && (w_off == OFF_CTRL) && wbs_sel_i[0] && wbs_data_i[CTRL_START];
  assign w_sts_clr = w_wr && (w_off == OFF_STATUS);
  assign w_pop     = (r_state == ST_LOAD) && !w_empty;

  config_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_push    (w_push),
    .i_wdata   (wbs_data_i),
    .i_pop     (w_pop),
    .o_rdata_c (w_fifo_rdata),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // Read mux; unmapped offsets return zero
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata[CTRL_CEN]      = r_cen;
      OFF_COLSEL: w_rdata[NCOL-1:0]      = r_colsel;
      OFF_LEN:    w_rdata[LEN_W-1:0]     = r_len;
      OFF_STATUS: begin
        w_rdata[STS_BUSY] = r_busy;
        w_rdata[STS_OVF]  = r_ovf;
        w_rdata[STS_UNF]  = r_unf;
        w_rdata[STS_DONE] = r_done;
        w_rdata[STS_CNT_LSB +: STS_CNT_W] = STS_CNT_W'(w_count);
      end
`ifdef CONFIG_CRC_EN
      OFF_CRC:    w_rdata[15:0]          = r_crc;
`endif
      default:    w_rdata = '0;
    endcase
  end

  // Bus registers, sticky flags and the load FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_cen       <= 1'b0;
      r_colsel    <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_done      <= 1'b0;
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_mask      <= '0;
      r_busy      <= 1'b0;
      r_cfg_data  <= '0;
      r_cfg_shift <= '0;
      r_cfg_set   <= '0;
`ifdef CONFIG_CRC_EN
      r_crc       <= '0;
`endif
    end else begin
      r_ack   <= w_sel;
      r_rdata <= w_rd ? w_rdata : 32'h0;

      // Byte-masked register writes
      if (w_wr && (w_off == OFF_CTRL) && wbs_sel_i[0]) r_cen <= wbs_data_i[CTRL_CEN];
      if (w_wr && (w_off == OFF_COLSEL)) begin
        for (int i = 0; i < int'(NCOL); i++)
          if (wbs_sel_i[i/8]) r_colsel[i] <= wbs_data_i[i];
      end
      if (w_wr && (w_off == OFF_LEN)) begin
        for (int i = 0; i < int'(LEN_W); i++)
          if (wbs_sel_i[i/8]) r_len[i] <= wbs_data_i[i];
      end

      // Clear first so a same-cycle set from the engine wins
      if (w_sts_clr) begin
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
        r_done <= 1'b0;
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;

      // Strobes are single-cycle unless re-asserted below
      r_cfg_data  <= '0;
      r_cfg_shift <= '0;
      r_cfg_set   <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_start && (r_len != '0) && (r_colsel != '0)) begin
            r_state     <= ST_LOAD;
            r_remaining <= r_len;
            r_mask      <= r_colsel;
            r_busy      <= 1'b1;
`ifdef CONFIG_CRC_EN
            r_crc       <= CRC_INIT;
`endif
          end
        end
        ST_LOAD: begin
          if (!w_empty) begin
            r_sr     <= w_fifo_rdata;
            r_bitcnt <= '0;
            r_state  <= ST_SHIFT;
          end else begin
            r_unf <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_cfg_shift <= r_mask;
          r_cfg_data  <= r_mask & {NCOL{r_sr[0]}};
          r_sr        <= {1'b0, r_sr[31:1]};
          r_remaining <= r_remaining - LEN_W'(1);
          r_bitcnt    <= r_bitcnt + 5'd1;
`ifdef CONFIG_CRC_EN
          r_crc       <= crc16_step(r_crc, r_sr[0]);
`endif
          // Length exhaustion takes precedence; leftover word bits are dropped
          if (r_remaining == LEN_W'(1))  r_state <= ST_SET;
          else if (r_bitcnt == 5'd31)    r_state <= ST_LOAD;
        end
        ST_SET: begin
          r_cfg_set <= r_mask;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o     = r_ack;
  assign wbs_data_o    = r_rdata;
  assign cen           = r_cen;
  assign cfg_data_out  = r_cfg_data;
  assign cfg_shift_out = r_cfg_shift;
  assign cfg_set_out   = r_cfg_set;
  assign busy          = r_busy;

endmodule

// File: tb/tb_config_chain_loader.sv
// Testbench for config_chain_loader: register table plus scoreboarded chain loads.
module tb_config_chain_loader;

  localparam logic [31:0] BASE   = 32'h3000_1000;
  localparam logic [7:0]  A_CTRL = 8'h00;
  localparam logic [7:0]  A_COL  = 8'h04;
  localparam logic [7:0]  A_LEN  = 8'h08;
  localparam logic [7:0]  A_DATA = 8'h0C;
  localparam logic [7:0]  A_STS  = 8'h10;
  localparam logic [7:0]  A_CRC  = 8'h14;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] dat_o;
  logic        cen;
  logic [3:0]  cfg_data;
  logic [3:0]  cfg_shift;
  logic [3:0]  cfg_set;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Expected chain events {set, shift, data}, one per non-idle output cycle
  logic [11:0] sb[$];

  config_chain_loader #(
    .BASE_ADDR  (BASE),
    .NCOL       (4),
    .FIFO_DEPTH (8),
    .LEN_W      (16)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_data_i    (dat_i),
    .wbs_addr_i    (addr),
    .wbs_ack_o     (ack),
    .wbs_data_o    (dat_o),
    .cen           (cen),
    .cfg_data_out  (cfg_data),
    .cfg_shift_out (cfg_shift),
    .cfg_set_out   (cfg_set),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Chain output monitor, sampled mid-cycle
  always @(negedge clk) begin : mon
    logic [11:0] act;
    act = {cfg_set, cfg_shift, cfg_data};
    if (!rst && (act != 12'h0)) begin
      if (sb.size() == 0) check("unexpected_strobe", 32'(act), 32'h0);
      else                check("chain_out", 32'(act), 32'(sb.pop_front()));
    end
  end

  task automatic sb_word(input logic [31:0] w, input int nbits, input logic [3:0] m);
    for (int i = 0; i < nbits; i++) sb.push_back({4'h0, m, w[i] ? m : 4'h0});
  endtask

  task automatic sb_set(input logic [3:0] m);
    sb.push_back({m, 4'h0, 4'h0});
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
    logic [15:0] sh;
    sh = {c[14:0], 1'b0};
    return (c[15] ^ b) ? (sh ^ 16'h1021) : sh;
  endfunction

  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] r);
    int lat;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; addr = BASE | 32'(off); sel = s; dat_i = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 4);
    r = dat_o;
    check("ack_latency", 32'(lat), 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] junk;
    wb_xfer(1'b1, off, 4'hF, d, junk);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, off, 4'hF, 32'h0, v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
    if (n >= budget) sb.delete();
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  off;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_op_t;

  reg_op_t tbl [19];

  initial begin : main
    logic [31:0] v;
    logic [15:0] crc;
    int nack;

    tbl[0]  = '{1'b1, A_CTRL, 4'hF, 32'h0000_0001, 32'h0};
    tbl[1]  = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};
    tbl[2]  = '{1'b1, A_COL,  4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b0, A_COL,  4'hF, 32'h0,         32'h0000_000F};
    tbl[4]  = '{1'b1, A_COL,  4'hE, 32'h0000_0000, 32'h0};
    tbl[5]  = '{1'b0, A_COL,  4'hF, 32'h0,         32'h0000_000F};
    tbl[6]  = '{1'b1, A_LEN,  4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b0, A_LEN,  4'hF, 32'h0,         32'h0000_BEEF};
    tbl[8]  = '{1'b1, A_LEN,  4'h2, 32'h0000_1200, 32'h0};
    tbl[9]  = '{1'b0, A_LEN,  4'hF, 32'h0,         32'h0000_12EF};
    tbl[10] = '{1'b0, 8'h18,  4'hF, 32'h0,         32'h0000_0000};
    tbl[11] = '{1'b1, A_DATA, 4'h7, 32'h0000_1234, 32'h0};
    tbl[12] = '{1'b0, A_STS,  4'hF, 32'h0,         32'h0000_0000};
    tbl[13] = '{1'b1, A_CTRL, 4'h0, 32'h0000_0000, 32'h0};
    tbl[14] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};
    tbl[15] = '{1'b1, A_CTRL, 4'h1, 32'h0000_0000, 32'h0};
    tbl[16] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0000};
    tbl[17] = '{1'b1, A_CTRL, 4'hF, 32'h0000_0001, 32'h0};
    tbl[18] = '{1'b0, A_CTRL, 4'hF, 32'h0,         32'h0000_0001};

    // Reset
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rdata", dat_o, 32'h0);
    check("rst_outputs", 32'({ack, cen, cfg_data, cfg_shift, cfg_set, busy}), 32'h0);
    rd_chk("rst_status", A_STS, 32'h0);
    @(posedge clk); #1;
    check("ack_single_cycle", 32'(ack), 32'h0);
    rd_chk("rst_crc", A_CRC, 32'h0);

    // Unselected address: no ack, no write
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = 32'h3000_1104; sel = 4'hF; dat_i = 32'h5;
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    check("unsel_no_ack", 32'(nack), 32'h0);
    rd_chk("unsel_no_write", A_COL, 32'h0);

    // Register table
    for (int i = 0; i < 19; i++) begin
      wb_xfer(tbl[i].w, tbl[i].off, tbl[i].s, tbl[i].d, v);
      if (!tbl[i].w) check($sformatf("reg_tbl[%0d]", i), v, tbl[i].exp);
    end
    check("cen_port", 32'(cen), 32'h1);

    // Basic load: 40 bits on columns 0 and 2
    wr(A_COL, 32'h5);
    wr(A_LEN, 32'd40);
    wr(A_DATA, 32'hA5A5_A5A5);
    wr(A_DATA, 32'h0000_00FF);
    sb_word(32'hA5A5_A5A5, 32, 4'b0101);
    sb_word(32'h0000_00FF, 8, 4'b0101);
    sb_set(4'b0101);
    wr(A_CTRL, 32'h3);
    wait_idle("basic_done", 300);
    rd_chk("basic_status", A_STS, 32'h0000_0008);
    wr(A_STS, 32'h0);
    rd_chk("status_clear", A_STS, 32'h0);

    // Underflow: 64 bits with a single word queued
    wr(A_COL, 32'hA);
    wr(A_LEN, 32'd64);
    wr(A_DATA, 32'h1357_9BDF);
    sb_word(32'h1357_9BDF, 32, 4'b1010);
    sb_word(32'hCAFE_F00D, 32, 4'b1010);
    sb_set(4'b1010);
    wr(A_CTRL, 32'h3);
    repeat (60) @(posedge clk);
    #1;
    check("unf_stall_pending", 32'(sb.size()), 32'd33);
    rd_chk("unf_status", A_STS, 32'h0000_0005);
    wr(A_DATA, 32'hCAFE_F00D);
    wait_idle("unf_done", 300);
    rd_chk("unf_final_status", A_STS, 32'h0000_000C);
    wr(A_STS, 32'h0);

    // Overflow: ninth push dropped
    for (int k = 1; k <= 9; k++) wr(A_DATA, 32'(k) * 32'h1357_9BDF);
    rd_chk("ovf_status", A_STS, 32'h0000_0802);
    wr(A_COL, 32'h1);
    wr(A_LEN, 32'd256);
    for (int k = 1; k <= 8; k++) sb_word(32'(k) * 32'h1357_9BDF, 32, 4'b0001);
    sb_set(4'b0001);
    wr(A_CTRL, 32'h3);
    wait_idle("ovf_done", 600);
    rd_chk("ovf_final_status", A_STS, 32'h0000_000A);
    wr(A_STS, 32'h0);

    // Ignored STARTs
    wr(A_COL, 32'h0);
    wr(A_LEN, 32'd8);
    wr(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("start_colsel0_busy", 32'(busy), 32'h0);
    rd_chk("start_colsel0_status", A_STS, 32'h0);
    wr(A_COL, 32'h1);
    wr(A_LEN, 32'd0);
    wr(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("start_len0_busy", 32'(busy), 32'h0);
    wr(A_COL, 32'h3);
    wr(A_LEN, 32'd40);
    wr(A_DATA, 32'hFACE_B00C);
    wr(A_DATA, 32'h0000_0055);
    sb_word(32'hFACE_B00C, 32, 4'b0011);
    sb_word(32'h0000_0055, 8, 4'b0011);
    sb_set(4'b0011);
    wr(A_CTRL, 32'h3);
    wr(A_COL, 32'hC);
    wr(A_LEN, 32'd8);
    check("restart_while_busy", 32'(busy), 32'h1);
    wr(A_CTRL, 32'h3);
    wait_idle("restart_done", 300);
    rd_chk("colsel_accepted", A_COL, 32'hC);
    rd_chk("len_accepted", A_LEN, 32'd8);
    rd_chk("restart_status", A_STS, 32'h0000_0008);
    wr(A_STS, 32'h0);

    // CRC over 8 bits of 0x31
    wr(A_COL, 32'h1);
    wr(A_LEN, 32'd8);
    wr(A_DATA, 32'h0000_0031);
    sb_word(32'h0000_0031, 8, 4'b0001);
    sb_set(4'b0001);
    wr(A_CTRL, 32'h3);
    wait_idle("crc_load_done", 200);
    crc = 16'hFFFF;
    v = 32'h0000_0031;
    for (int i = 0; i < 8; i++) crc = crc_ref(crc, v[i]);
`ifdef CONFIG_CRC_EN
    rd_chk("crc_value", A_CRC, 32'(crc));
`else
    rd_chk("crc_absent", A_CRC, 32'h0);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Wishbone-slave bitstream loader that drives the fabric's per-column configuration chains (shift/set/data), one chain per column.
- Sits between the Caravel management Wishbone bus and the fpga column chains. Firmware pushes 32-bit words into a FIFO; the block serialises them into the selected columns, then issues a single set pulse.
- Also owns the fabric configuration enable (cen).

Parameters:
- BASE_ADDR, 32'h3000_1000, Wishbone base address; register offsets are relative to it.
- NCOL, 4, number of column chains driven.
- FIFO_DEPTH, 8, data FIFO entries (power of two).
- LEN_W, 16, width of the chain-length register (bits per load).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte write mask
- wbs_data_i  in  32  write data
- wbs_addr_i  in  32  address
- wbs_ack_o  out  1  registered acknowledge
- wbs_data_o  out  32  read data
- cen  out  1  fabric configuration enable
- cfg_data_out  out  NCOL  serial config bit per column
- cfg_shift_out  out  NCOL  shift strobe per column
- cfg_set_out  out  NCOL  latch strobe per column
- busy  out  1  load in progress

Behaviour:
- One clock, wb_clk_i. Reset is synchronous, active-high on wb_rst_i; all state clears on the first rising edge with wb_rst_i=1.
- Reset values:
  - all outputs 0
  - FIFO empty
  - FSM in IDLE
  - all registers 0
- Bus transaction:
  - Selected when stb&cyc and addr[31:8]==BASE_ADDR[31:8].
  - wbs_ack_o rises the cycle after selection, held for exactly 1 cycle, then 0 for at least 1 cycle.
  - No ack for unselected addresses.
  - Reads of unmapped offsets return 0.
  - wbs_sel_i masks CTRL/COLSEL/LEN writes byte-wise. DATA push needs sel==4'hF; otherwise it is ignored.
- Registers:
  - 0x00 CTRL: bit0 cen (drives the cen port directly); bit1 START (write-1 pulse, self-clearing).
  - 0x04 COLSEL: bits[NCOL-1:0] column mask.
  - 0x08 LEN: bits[LEN_W-1:0], total bits to shift.
  - 0x0C DATA: write pushes the word. Write while full drops the word and sets OVF.
  - 0x10 STATUS (read-only): bit0 busy; bit1 OVF (sticky); bit2 UNF (sticky); bits[11:8] FIFO count; bit3 DONE (sticky).
  - Any write to STATUS clears OVF, UNF and DONE.
- FSM IDLE -> LOAD -> SHIFT -> SET -> IDLE:
  - IDLE: START with LEN!=0 and COLSEL!=0 -> LOAD; remaining-bit count loaded from LEN. START with LEN==0 or COLSEL==0 is ignored. START while busy is ignored.
  - LOAD: if the FIFO is non-empty, pop into a 32-bit shift register and go to SHIFT. If empty, wait in LOAD and set UNF. No shift strobes are issued while waiting.
  - SHIFT: each cycle, data is LSB-first.
    - cfg_data_out[c]=sr[0] and cfg_shift_out[c]=1 for each c with COLSEL[c]=1; both are 0 for unselected columns.
    - sr shifts right; remaining decrements.
    - remaining reaches 0 -> SET (unused bits of the last word are discarded). 32 bits consumed -> LOAD.
  - SET: cfg_set_out[c]=COLSEL[c] for exactly 1 cycle; DONE set; -> IDLE.
- Outputs are registered, so strobe/data are coherent in the same cycle.
- busy=1 in LOAD, SHIFT and SET.
- Push and pop in the same cycle:
  - Allowed when not full.
  - When full, a pop in the same cycle makes the push succeed.
- COLSEL and LEN writes during busy are accepted into the registers but do not affect the active load; the mask is latched at START.

Optional Feature:
- CONFIG_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated with every bit shifted out.
  - Read at 0x14. CRC resets to 0xFFFF on START.
- CONFIG_CRC_EN undefined: no CRC logic; 0x14 reads 0.

Decomposition:
- Package config_loader_pkg holds:
  - register offsets
  - STATUS bit indices
  - FSM state enum
  - CRC polynomial/init constants
- One sub-module, config_word_fifo: synchronous FIFO with push/pop/full/empty/count and simultaneous push-pop support.

Test Plan:
- Reset: drive wb_rst_i 2 cycles, then check all outputs 0, STATUS reads 0, and ack appears 1 cycle after a strobe.
- Basic load: COLSEL=4'b0101, LEN=40, push 0xA5A5_A5A5 and 0x0000_00FF, START. Expect:
  - 40 cycles of cfg_shift_out=4'b0101
  - bit sequence = word0 LSB-first, then 8 ones
  - one cycle cfg_set_out=4'b0101
  - DONE=1
- Underflow: LEN=64, push one word, START. Expect shift stalls after 32 cycles with UNF=1 and busy=1. A second push resumes shifting; completion follows after 32 more shifts.
- Overflow: push 9 words with FIFO_DEPTH=8 and no START. Expect count=8, OVF=1; the 9th word is never shifted.
- Ignored START: START with COLSEL=0, then START during an active load. Expect no state change and an unchanged bit count.
- CRC (CONFIG_CRC_EN): LEN=8, push 0x0000_0031 (bits shift LSB-first, so 0x31 enters the CRC bit-reversed as 0x8C). Expect 0x14 equal to the golden-model value of CRC-16-CCITT over bit stream 1,0,0,0,1,1,0,0.
